// File: rtl/array_to_position_if.sv
// array_to_position_if
//   Handshake bundle for the meter-bar decoder.
//   Upstream side : i_valid / i_ready / i_array (32-bit bar image, bit 0 lowest)
//   Downstream side: o_valid / o_ready / o_level / o_peak / o_empty / o_malformed
//   master : the environment (drives array + o_ready, observes results)
//   slave  : the decoder
interface array_to_position_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_array;
    logic        o_valid;
    logic        o_ready;
    logic [5:0]  o_level;
    logic [4:0]  o_peak;
    logic        o_empty;
    logic        o_malformed;

    modport master (
        output i_valid, i_array, o_ready,
        input  i_ready, o_valid, o_level, o_peak, o_empty, o_malformed
    );

    modport slave (
        input  i_valid, i_array, o_ready,
        output i_ready, o_valid, o_level, o_peak, o_empty, o_malformed
    );
endinterface

// File: rtl/array_to_position.sv
// array_to_position
//   Decodes a 32-segment meter bar image into the length of the contiguous
//   bar from bit 0 (level), the highest lit segment (peak), an empty flag and
//   a malformed flag (two or more lit segments detached from the bar).
//   The captured array is walked one bit per clock, so every result appears
//   exactly 32 edges after the accepting edge, independent of the data.
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : array_to_position_if.slave (input handshake + result handshake)
module array_to_position (
    input  logic                  clk,
    input  logic                  reset,
    array_to_position_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic [5:0] level;
        logic [4:0] peak;
        logic       empty;
        logic       malformed;
    } result_t;

    state_t      state_q, state_d;

    logic [31:0] arr_q,    arr_d;
    logic [4:0]  idx_q,    idx_d;
    logic [5:0]  level_q,  level_d;
    logic [4:0]  peak_q,   peak_d;
    logic        any_q,    any_d;
    logic        in_run_q, in_run_d;
    logic [1:0]  extra_q,  extra_d;
    result_t     res_q,    res_d;

    logic        bit_cur;

    assign bit_cur = arr_q[idx_q];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus scan datapath
    always_comb begin
        state_d  = state_q;
        arr_d    = arr_q;
        idx_d    = idx_q;
        level_d  = level_q;
        peak_d   = peak_q;
        any_d    = any_q;
        in_run_d = in_run_q;
        extra_d  = extra_q;
        res_d    = res_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    arr_d    = bus.i_array;
                    idx_d    = 5'd0;
                    level_d  = 6'd0;
                    peak_d   = 5'd0;
                    any_d    = 1'b0;
                    in_run_d = 1'b1;
                    extra_d  = 2'd0;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                if (bit_cur) begin
                    peak_d = idx_q;
                    any_d  = 1'b1;
                    if (in_run_q)
                        level_d = level_q + 6'd1;
                    else if (extra_q != 2'd3)
                        extra_d = extra_q + 2'd1;
                end else begin
                    // once the bar breaks it never resumes for this scan
                    in_run_d = 1'b0;
                end

                // Bit 31 always terminates the walk; the result is built from
                // the updated accumulators so the last bit is included.
                if (idx_q == 5'd31) begin
                    state_d         = DONE;
                    res_d.level     = level_d;
                    res_d.peak      = peak_d;
                    res_d.empty     = ~any_d;
                    res_d.malformed = (extra_d >= 2'd2);
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end

            DONE: begin
                if (bus.o_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Datapath registers; reset discards any in-flight scan
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arr_q    <= '0;
            idx_q    <= '0;
            level_q  <= '0;
            peak_q   <= '0;
            any_q    <= 1'b0;
            in_run_q <= 1'b0;
            extra_q  <= '0;
            res_q    <= '0;
        end else begin
            arr_q    <= arr_d;
            idx_q    <= idx_d;
            level_q  <= level_d;
            peak_q   <= peak_d;
            any_q    <= any_d;
            in_run_q <= in_run_d;
            extra_q  <= extra_d;
            res_q    <= res_d;
        end
    end

    assign bus.i_ready     = (state_q == IDLE);
    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_level     = res_q.level;
    assign bus.o_peak      = res_q.peak;
    assign bus.o_empty     = res_q.empty;
    assign bus.o_malformed = res_q.malformed;
endmodule

// File: tb/tb_array_to_position.sv
module tb_array_to_position;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    array_to_position_if bus ();

    array_to_position dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] lvl;
        logic [4:0] pk;
        logic       emp;
        logic       mal;
        int         acc;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: on each new result, pop the oldest expectation and compare
    logic prev_valid;
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.o_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_o_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_latency"}, cyc - e.acc, 32);
                    chk({e.name, "_level"}, {26'd0, bus.o_level}, {26'd0, e.lvl});
                    chk({e.name, "_peak"}, {27'd0, bus.o_peak}, {27'd0, e.pk});
                    chk({e.name, "_empty"}, {31'd0, bus.o_empty}, {31'd0, e.emp});
                    chk({e.name, "_malformed"}, {31'd0, bus.o_malformed}, {31'd0, e.mal});
                end
            end
            prev_valid <= bus.o_valid;
        end
    end

    // Called away from the clock edge; presents the array for one edge
    task automatic send(input string name, input logic [31:0] arr, input logic [5:0] lvl,
                        input logic [4:0] pk, input logic emp, input logic mal, input bit push);
        exp_t e;
        chk({name, "_i_ready"}, {31'd0, bus.i_ready}, 32'd1);
        bus.i_valid = 1'b1;
        bus.i_array = arr;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_array = 32'hDEAD_BEEF;  // must be ignored during the scan
        if (push) begin
            e.lvl = lvl; e.pk = pk; e.emp = emp; e.mal = mal; e.acc = cyc; e.name = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (seen && !bus.o_valid) begin ok = 1; break; end
            if (bus.o_valid) seen = 1;
        end
        if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run(input string name, input logic [31:0] arr, input logic [5:0] lvl,
                       input logic [4:0] pk, input logic emp, input logic mal);
        send(name, arr, lvl, pk, emp, mal, 1'b1);
        wait_done(name);
    endtask

    initial begin
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        bus.i_valid = 1'b0;
        bus.i_array = '0;
        bus.o_ready = 1'b1;
        reset       = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_outputs", {19'd0, bus.o_level, bus.o_peak, bus.o_empty, bus.o_malformed}, 32'd0);
        reset = 1'b1;

        // first edge after release accepts
        run("plain_bar",   32'h0000_03FF, 6'd10, 5'd9,  1'b0, 1'b0);
        run("bar_peak",    32'h0000_21FF, 6'd9,  5'd13, 1'b0, 1'b0);
        run("malformed",   32'h0000_0A07, 6'd3,  5'd11, 1'b0, 1'b1);
        run("empty",       32'h0000_0000, 6'd0,  5'd0,  1'b1, 1'b0);
        run("full",        32'hFFFF_FFFF, 6'd32, 5'd31, 1'b0, 1'b0);
        run("top_only",    32'h8000_0000, 6'd0,  5'd31, 1'b0, 1'b0);
        run("sat_extra",   32'hAAAA_AAA9, 6'd1,  5'd31, 1'b0, 1'b1);

        // back-pressure: result held while o_ready=0
        bus.o_ready = 1'b0;
        send("bp", 32'h0000_0A07, 6'd3, 5'd11, 1'b0, 1'b1, 1'b1);
        begin
            bit got = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.o_valid) begin got = 1; break; end
            end
            if (!got) chk("bp_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_o_valid", {31'd0, bus.o_valid}, 32'd1);
            chk("bp_i_ready", {31'd0, bus.i_ready}, 32'd0);
            chk("bp_hold", {19'd0, bus.o_level, bus.o_peak, bus.o_empty, bus.o_malformed},
                {19'd0, 6'd3, 5'd11, 1'b0, 1'b1});
        end
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("bp_release_o_valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);

        // abort mid-scan with reset
        send("abort", 32'hFFFF_0000, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("abort_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("abort_outputs", {19'd0, bus.o_level, bus.o_peak, bus.o_empty, bus.o_malformed}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run("after_abort", 32'h0000_001F, 6'd5, 5'd4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
